// File: rtl/riscv_pkg.sv
// Shared definitions for the interrupt-context unstack engine: state encoding,
// frame-word to register restore order, and word-size helper.
package riscv_pkg;

  localparam int unsigned SU_FSM_W = 3;

  typedef enum logic [SU_FSM_W-1:0] {
    StIdle    = 3'd0,
    StReq     = 3'd1,
    StWait    = 3'd2,
    StRestore = 3'd3,
    StDone    = 3'd4
  } su_unstack_state_e;

  // Frame order: ra, t0-t2, a0-a7, t3-t6
  localparam logic [4:0] SU_RESTORE_MAP [16] = '{
    5'd1,  5'd5,  5'd6,  5'd7,
    5'd10, 5'd11, 5'd12, 5'd13, 5'd14, 5'd15, 5'd16, 5'd17,
    5'd28, 5'd29, 5'd30, 5'd31
  };

  function automatic int unsigned su_word_bytes(input int unsigned data_width);
    return data_width / 8;
  endfunction

  function automatic logic [4:0] su_restore_reg(input int unsigned idx);
    return SU_RESTORE_MAP[idx[3:0]];
  endfunction

endpackage

// File: rtl/riscv_su_unstack_addr_gen.sv
// Base/count/index registers of the unstack engine; derives the current read
// address and the popped stack pointer, both modulo 2^ADDR_WIDTH.
module riscv_su_unstack_addr_gen
  import riscv_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 64,
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned CNT_W      = 5
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  en_i,
  input  logic                  load_i,
  input  logic                  inc_i,
  input  logic [ADDR_WIDTH-1:0] base_i,
  input  logic [CNT_W-1:0]      cnt_i,
  output logic [ADDR_WIDTH-1:0] base_o,
  output logic [CNT_W-1:0]      idx_o,
  output logic [CNT_W-1:0]      cnt_o,
  output logic [ADDR_WIDTH-1:0] rd_addr_o,
  output logic [ADDR_WIDTH-1:0] sp_o
);

  localparam logic [ADDR_WIDTH-1:0] WordBytes = ADDR_WIDTH'(su_word_bytes(DATA_WIDTH));

  logic [ADDR_WIDTH-1:0] base_q;
  logic [CNT_W-1:0]      idx_q;
  logic [CNT_W-1:0]      cnt_q;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      base_q <= '0;
      idx_q  <= '0;
      cnt_q  <= '0;
    end else if (en_i) begin
      if (load_i) begin
        base_q <= base_i;
        idx_q  <= '0;
        cnt_q  <= cnt_i;
      end else if (inc_i) begin
        idx_q <= idx_q + CNT_W'(1);
      end
    end
  end

  assign base_o    = base_q;
  assign idx_o     = idx_q;
  assign cnt_o     = cnt_q;
  assign rd_addr_o = base_q + ADDR_WIDTH'(idx_q) * WordBytes;
  assign sp_o      = base_q + ADDR_WIDTH'(cnt_q) * WordBytes;

endmodule

// File: rtl/riscv_su_unstack_engine.sv
// Interrupt-return unstack engine: pops a context frame word by word into the
// register file. Tail-chain support is enabled by RISCV_SU_UNSTACK_TAILCHAIN_EN.
module riscv_su_unstack_engine
  import riscv_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH      = 64,
  parameter int unsigned DATA_WIDTH      = 64,
  parameter int unsigned MAX_FRAME_WORDS = 16,
  parameter int unsigned SU_FSM_WIDTH    = 3,
  localparam int unsigned CNT_W          = $clog2(MAX_FRAME_WORDS + 1)
) (
  input  logic                    clk,
  input  logic                    nreset,
  input  logic                    enable,
  input  logic                    i_ret_interr,
  input  logic [ADDR_WIDTH-1:0]   i_frame_base,
  input  logic [CNT_W-1:0]        i_frame_words,
  input  logic                    i_abort,
  input  logic                    i_interr_preemtion,
  output logic                    o_rd_req,
  output logic [ADDR_WIDTH-1:0]   o_rd_addr,
  input  logic                    i_rd_gnt,
  input  logic                    i_rd_valid,
  input  logic [DATA_WIDTH-1:0]   i_rd_data,
  output logic                    o_rf_we,
  output logic [4:0]              o_rf_idx,
  output logic [DATA_WIDTH-1:0]   o_rf_data,
  output logic [ADDR_WIDTH-1:0]   o_sp,
  output logic                    o_all_unstacked,
  output logic                    o_tailchain,
  output logic                    o_busy,
  output logic [SU_FSM_WIDTH-1:0] o_fsm_status
);

  su_unstack_state_e state_q, state_d;
  logic pend_q, pend_d;
  logic tc_d, load, inc, preempt;
  logic rd_req_q, rf_we_q, done_q, tc_q, busy_q;
  logic [4:0]            rf_idx_q;
  logic [DATA_WIDTH-1:0] rf_data_q;
  logic [ADDR_WIDTH-1:0] sp_q, base, sp_final;
  logic [CNT_W-1:0]      idx, cnt, cnt_clamped;

`ifdef RISCV_SU_UNSTACK_TAILCHAIN_EN
  assign preempt = i_interr_preemtion;
`else
  logic unused_preempt;
  assign unused_preempt = i_interr_preemtion;
  assign preempt        = 1'b0;
`endif

  assign cnt_clamped = (i_frame_words > CNT_W'(MAX_FRAME_WORDS)) ? CNT_W'(MAX_FRAME_WORDS)
                                                                 : i_frame_words;

  riscv_su_unstack_addr_gen #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (DATA_WIDTH),
    .CNT_W      (CNT_W)
  ) u_addr_gen (
    .clk_i     (clk),
    .rst_ni    (nreset),
    .en_i      (enable),
    .load_i    (load),
    .inc_i     (inc),
    .base_i    (i_frame_base),
    .cnt_i     (cnt_clamped),
    .base_o    (base),
    .idx_o     (idx),
    .cnt_o     (cnt),
    .rd_addr_o (o_rd_addr),
    .sp_o      (sp_final)
  );

  always_comb begin
    state_d = state_q;
    pend_d  = pend_q;
    tc_d    = 1'b0;
    load    = 1'b0;
    inc     = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (i_ret_interr) begin
          load    = 1'b1;
          pend_d  = 1'b0;
          state_d = (cnt_clamped == '0) ? StDone : StReq;
        end
      end
      StReq: begin
        if (preempt) begin
          tc_d    = 1'b1;
          state_d = StDone;
        end else if (i_rd_gnt) begin
          state_d = StWait;
        end
      end
      StWait: begin
        // Preemption cannot cut an outstanding read; defer it to RESTORE
        if (preempt) pend_d = 1'b1;
        if (i_rd_valid) state_d = StRestore;
      end
      StRestore: begin
        inc    = 1'b1;
        pend_d = 1'b0;
        if (preempt || pend_q) begin
          tc_d    = 1'b1;
          state_d = StDone;
        end else if (idx + CNT_W'(1) == cnt) begin
          state_d = StDone;
        end else begin
          state_d = StReq;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
    if (i_abort && state_q != StIdle) begin
      state_d = StIdle;
      pend_d  = 1'b0;
      tc_d    = 1'b0;
      inc     = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!nreset) begin
      state_q   <= StIdle;
      pend_q    <= 1'b0;
      rd_req_q  <= 1'b0;
      rf_we_q   <= 1'b0;
      rf_idx_q  <= '0;
      rf_data_q <= '0;
      sp_q      <= '0;
      done_q    <= 1'b0;
      tc_q      <= 1'b0;
      busy_q    <= 1'b0;
    end else if (enable) begin
      state_q  <= state_d;
      pend_q   <= pend_d;
      rd_req_q <= (state_d == StReq);
      rf_we_q  <= (state_d == StRestore);
      busy_q   <= (state_d != StIdle);
      done_q   <= (state_d == StDone) && !tc_d;
      tc_q     <= (state_d == StDone) && tc_d;
      if (state_q == StWait && state_d == StRestore) begin
        rf_idx_q  <= su_restore_reg(32'(idx));
        rf_data_q <= i_rd_data;
      end
      // A zero-length frame finishes straight from IDLE, before base is latched
      if (state_d == StDone) begin
        sp_q <= (state_q == StIdle) ? i_frame_base : (tc_d ? base : sp_final);
      end
    end
  end

  assign o_rd_req        = rd_req_q;
  assign o_rf_we         = rf_we_q;
  assign o_rf_idx        = rf_idx_q;
  assign o_rf_data       = rf_data_q;
  assign o_sp            = sp_q;
  assign o_all_unstacked = done_q;
  assign o_busy          = busy_q;
  assign o_fsm_status    = SU_FSM_WIDTH'(state_q);
`ifdef RISCV_SU_UNSTACK_TAILCHAIN_EN
  assign o_tailchain = tc_q;
`else
  logic unused_tc;
  assign unused_tc   = tc_q;
  assign o_tailchain = 1'b0;
`endif

endmodule

// File: tb/tb_riscv_su_unstack_engine.sv
// Self-checking bench for riscv_su_unstack_engine: table-driven pops with a
// memory responder and scoreboard, plus hand sequences for abort/reset/freeze.
module tb_riscv_su_unstack_engine;

  logic        clk = 1'b0;
  logic        nreset, enable, i_ret_interr, i_abort, i_interr_preemtion;
  logic [63:0] i_frame_base;
  logic [4:0]  i_frame_words;
  logic        o_rd_req, i_rd_gnt, i_rd_valid, o_rf_we, o_all_unstacked, o_tailchain, o_busy;
  logic [63:0] o_rd_addr, i_rd_data, o_rf_data, o_sp;
  logic [4:0]  o_rf_idx;
  logic [2:0]  o_fsm_status;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  riscv_su_unstack_engine dut (
    .clk                (clk),
    .nreset             (nreset),
    .enable             (enable),
    .i_ret_interr       (i_ret_interr),
    .i_frame_base       (i_frame_base),
    .i_frame_words      (i_frame_words),
    .i_abort            (i_abort),
    .i_interr_preemtion (i_interr_preemtion),
    .o_rd_req           (o_rd_req),
    .o_rd_addr          (o_rd_addr),
    .i_rd_gnt           (i_rd_gnt),
    .i_rd_valid         (i_rd_valid),
    .i_rd_data          (i_rd_data),
    .o_rf_we            (o_rf_we),
    .o_rf_idx           (o_rf_idx),
    .o_rf_data          (o_rf_data),
    .o_sp               (o_sp),
    .o_all_unstacked    (o_all_unstacked),
    .o_tailchain        (o_tailchain),
    .o_busy             (o_busy),
    .o_fsm_status       (o_fsm_status)
  );

  typedef struct {
    logic [63:0] base;
    int          n;
    int          dly_word;
    int          dly;
    logic [63:0] exp_sp;
    int          exp_lat;
  } vec_t;

  typedef struct {
    logic [4:0]  idx;
    logic [63:0] data;
  } rf_exp_t;

  logic [4:0]  map_m [16] = '{5'd1, 5'd5, 5'd6, 5'd7, 5'd10, 5'd11, 5'd12, 5'd13,
                              5'd14, 5'd15, 5'd16, 5'd17, 5'd28, 5'd29, 5'd30, 5'd31};
  logic [63:0] addr_q[$];
  rf_exp_t     rf_q[$];
  vec_t        vecs[6];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] pat(input logic [63:0] a);
    return a ^ 64'hA5A5_5A5A_0F0F_F0F0;
  endfunction

  task automatic quiet_inputs();
    i_ret_interr       = 1'b0;
    i_abort            = 1'b0;
    i_interr_preemtion = 1'b0;
    i_rd_gnt           = 1'b0;
    i_rd_valid         = 1'b0;
  endtask

  task automatic start(input logic [63:0] base, input int n);
    i_frame_base  = base;
    i_frame_words = 5'(n);
    i_ret_interr  = 1'b1;
  endtask

  task automatic run_pop(input vec_t v);
    int          words, cyc, wcnt, wait_cnt;
    bit          done, valid_next;
    logic [63:0] resp, a;
    rf_exp_t     e;
    words = (v.n > 16) ? 16 : v.n;
    addr_q.delete();
    rf_q.delete();
    for (int w = 0; w < words; w++) addr_q.push_back(v.base + 64'(w) * 64'd8);
    start(v.base, v.n);
    cyc = 0; wcnt = 0; wait_cnt = 0; done = 0; valid_next = 0; resp = '0;
    while (!done && cyc < 300) begin
      @(negedge clk);
      cyc++;
      quiet_inputs();
      if (valid_next) begin
        i_rd_valid = 1'b1;
        i_rd_data  = resp;
        e.idx      = map_m[4'(wcnt - 1)];
        e.data     = resp;
        rf_q.push_back(e);
        valid_next = 0;
      end
      if (o_rf_we) begin
        if (rf_q.size() == 0) begin
          chk("rf_we_unexpected", {63'b0, o_rf_we}, 64'd0);
        end else begin
          e = rf_q.pop_front();
          chk("rf_idx", {59'b0, o_rf_idx}, {59'b0, e.idx});
          chk("rf_data", o_rf_data, e.data);
        end
      end
      if (o_all_unstacked) begin
        chk("sp", o_sp, v.exp_sp);
        chk("done_latency", 64'(cyc), 64'(v.exp_lat));
        chk("words_read", 64'(wcnt), 64'(words));
        chk("restores_pending", 64'(rf_q.size()), 64'd0);
        done = 1;
      end
      if (o_rd_req) begin
        if (addr_q.size() == 0) begin
          chk("rd_req_unexpected", {63'b0, o_rd_req}, 64'd0);
        end else begin
          chk("rd_addr", o_rd_addr, addr_q[0]);
          if (wcnt == v.dly_word && wait_cnt < v.dly) begin
            wait_cnt++;
          end else begin
            i_rd_gnt   = 1'b1;
            a          = addr_q.pop_front();
            resp       = pat(a);
            valid_next = 1;
            wcnt++;
          end
        end
      end
    end
    if (!done) chk("done_seen", {63'b0, done}, 64'd1);
    @(negedge clk);
    chk("idle_after_done", {63'b0, o_busy}, 64'd0);
  endtask

  initial begin
    vecs[0] = '{64'h1000, 4, -1, 0, 64'h1020, 13};
    vecs[1] = '{64'h2000, 0, -1, 0, 64'h2000, 1};
    vecs[2] = '{64'h1000, 4, 1, 5, 64'h1020, 18};
    vecs[3] = '{64'hFFFF_FFFF_FFFF_FFF0, 4, -1, 0, 64'h10, 13};
    vecs[4] = '{64'h4000, 20, -1, 0, 64'h4080, 49};
    vecs[5] = '{64'h80, 1, 0, 2, 64'h88, 6};

    nreset = 1'b0; enable = 1'b1;
    i_frame_base = '0; i_frame_words = '0; i_rd_data = '0;
    quiet_inputs();
    repeat (3) @(negedge clk);
    chk("rst_rd_req", {63'b0, o_rd_req}, 64'd0);
    chk("rst_rd_addr", o_rd_addr, 64'd0);
    chk("rst_rf_we", {63'b0, o_rf_we}, 64'd0);
    chk("rst_rf_idx", {59'b0, o_rf_idx}, 64'd0);
    chk("rst_rf_data", o_rf_data, 64'd0);
    chk("rst_sp", o_sp, 64'd0);
    chk("rst_done", {63'b0, o_all_unstacked}, 64'd0);
    chk("rst_tailchain", {63'b0, o_tailchain}, 64'd0);
    chk("rst_busy", {63'b0, o_busy}, 64'd0);
    chk("rst_status", {61'b0, o_fsm_status}, 64'd0);
    nreset = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 6; i++) begin
      run_pop(vecs[i]);
      @(negedge clk);
    end

    // Abort in WAIT of the first word; the late response must be ignored
    start(64'h1000, 4);
    @(negedge clk); quiet_inputs();
    chk("abort_req", {61'b0, o_fsm_status}, 64'd1);
    i_rd_gnt = 1'b1;
    @(negedge clk); quiet_inputs();
    chk("abort_wait", {61'b0, o_fsm_status}, 64'd2);
    i_abort = 1'b1;
    @(negedge clk); quiet_inputs();
    chk("abort_idle", {61'b0, o_fsm_status}, 64'd0);
    chk("abort_busy", {63'b0, o_busy}, 64'd0);
    i_rd_valid = 1'b1; i_rd_data = 64'hBAD;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk); quiet_inputs();
      chk("abort_quiet", {62'b0, o_rf_we, o_all_unstacked}, 64'd0);
    end

    // Reset mid-operation
    start(64'h5000, 2);
    @(negedge clk); quiet_inputs();
    i_rd_gnt = 1'b1;
    @(negedge clk); quiet_inputs();
    nreset = 1'b0;
    @(negedge clk); quiet_inputs();
    nreset = 1'b1;
    chk("rst_mid_status", {61'b0, o_fsm_status}, 64'd0);
    chk("rst_mid_busy", {63'b0, o_busy}, 64'd0);
    i_rd_valid = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk); quiet_inputs();
      chk("rst_mid_quiet", {61'b0, o_rf_we, o_all_unstacked, o_tailchain}, 64'd0);
    end

    // Clock-enable freeze in REQ, plus a start while busy that must be ignored
    start(64'h80, 1);
    @(negedge clk); quiet_inputs();
    enable = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("freeze_status", {61'b0, o_fsm_status}, 64'd1);
      chk("freeze_req", {63'b0, o_rd_req}, 64'd1);
    end
    enable = 1'b1; i_rd_gnt = 1'b1;
    @(negedge clk); quiet_inputs();
    chk("freeze_wait", {61'b0, o_fsm_status}, 64'd2);
    i_rd_valid = 1'b1; i_rd_data = pat(64'h80);
    start(64'hFF00, 3);
    @(negedge clk); quiet_inputs();
    chk("freeze_rf_data", o_rf_data, pat(64'h80));
    chk("freeze_rf_idx", {59'b0, o_rf_idx}, 64'd1);
    @(negedge clk);
    chk("freeze_done", {63'b0, o_all_unstacked}, 64'd1);
    chk("freeze_sp", o_sp, 64'h88);
    @(negedge clk);

    // Preemption in REQ of word 2
    start(64'h3000, 4);
    @(negedge clk); quiet_inputs();
    i_rd_gnt = 1'b1;
    @(negedge clk); quiet_inputs();
    i_rd_valid = 1'b1; i_rd_data = pat(64'h3000);
    @(negedge clk); quiet_inputs();
    chk("tc_rf_we", {63'b0, o_rf_we}, 64'd1);
    @(negedge clk); quiet_inputs();
    chk("tc_addr", o_rd_addr, 64'h3008);
    i_interr_preemtion = 1'b1;
    @(negedge clk); quiet_inputs();
`ifdef RISCV_SU_UNSTACK_TAILCHAIN_EN
    chk("tc_pulse", {63'b0, o_tailchain}, 64'd1);
    chk("tc_no_done", {63'b0, o_all_unstacked}, 64'd0);
    chk("tc_sp", o_sp, 64'h3000);
    @(negedge clk); quiet_inputs();
    chk("tc_idle", {62'b0, o_busy, o_tailchain}, 64'd0);
`else
    chk("tc_off_pulse", {63'b0, o_tailchain}, 64'd0);
    chk("tc_off_status", {61'b0, o_fsm_status}, 64'd1);
    i_abort = 1'b1;
    @(negedge clk); quiet_inputs();
    chk("tc_off_idle", {63'b0, o_busy}, 64'd0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
